udp_csum_accum: RTL

- Streaming 16-bit ones'-complement checksum accumulator for IPv4 header and UDP checksum generation.
- Consumes a 32-bit AXI-Stream byte stream; accepts a pseudo-header partial-sum seed; emits the final checksum as a single-beat stream.
- Its per-beat adder and both end-around-carry fold adders are built from chained lca_4bit slices (cout of each slice drives cin of the next).
- Sits upstream of the UDP/IP header inserter, in the tx path.

---
 rtl/udp_csum_accum.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/udp_csum_accum.sv
// Streaming ones'-complement checksum accumulator (IPv4 header / UDP) over a 32-bit byte stream.
// Every adder is a ripple of 4-bit lookahead slices so carry timing stays predictable per slice.

module lca_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    assign g = a & b;
    assign p = a ^ b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);
    assign s    = p ^ c;
endmodule

module lca_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);
    logic [W/4:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < W / 4; gi++) begin : g_slice
            lca_4bit u_slice (
                .a    (a[4*gi +: 4]),
                .b    (b[4*gi +: 4]),
                .cin  (carry[gi]),
                .s    (s[4*gi +: 4]),
                .cout (carry[gi+1])
            );
        end
    endgenerate

    assign cout = carry[W/4];
endmodule

module udp_csum_accum #(
    parameter int OUT_INVERT   = 1,
    parameter int ZERO_TO_FFFF = 1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [15:0] seed_in,
    input  logic [31:0] s_axis_tdata,
    input  logic [3:0]  s_axis_tkeep,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    output logic [15:0] csum_tdata,
    output logic        csum_tvalid,
    input  logic        csum_tready
);
    typedef enum logic [1:0] {ACCUM, FOLD1, FOLD2, OUT} state_t;

    state_t      state_reg;
    logic [31:0] acc_reg;
    logic        first_reg;
    logic        tready_reg;
    logic        tvalid_reg;
    logic [15:0] tdata_reg;

    logic [7:0]  byte_m [4];
    logic [15:0] w0;
    logic [15:0] w1;
    logic [15:0] pair_sum;
    logic        pair_c;
    logic [31:0] base;
    logic [31:0] beat_sum;
    logic        beat_cout_unused;
    logic [15:0] fold1_sum;
    logic        fold1_c;
    logic [15:0] fold2_sum;
    logic        fold2_cout_unused;
    logic [15:0] inv_sum;
    logic [15:0] final_sum;
    logic        in_hs;

    // Bytes outside tkeep contribute zero, which also pads an odd trailing byte.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_mask
            assign byte_m[gi] = s_axis_tkeep[gi] ? s_axis_tdata[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign w0   = {byte_m[0], byte_m[1]};
    assign w1   = {byte_m[2], byte_m[3]};
    assign base = first_reg ? {16'h0000, seed_in} : acc_reg;

    lca_add #(.W(16)) u_pair (
        .a (w0), .b (w1), .cin (1'b0), .s (pair_sum), .cout (pair_c)
    );

    lca_add #(.W(32)) u_beat (
        .a (base), .b ({15'h0000, pair_c, pair_sum}), .cin (1'b0),
        .s (beat_sum), .cout (beat_cout_unused)
    );

    lca_add #(.W(16)) u_fold1 (
        .a (acc_reg[15:0]), .b (acc_reg[31:16]), .cin (1'b0),
        .s (fold1_sum), .cout (fold1_c)
    );

    // Second fold injects the single carry bit through cin; it cannot carry out again.
    lca_add #(.W(16)) u_fold2 (
        .a (acc_reg[15:0]), .b (16'h0000), .cin (acc_reg[16]),
        .s (fold2_sum), .cout (fold2_cout_unused)
    );

    assign inv_sum   = (OUT_INVERT != 0) ? ~acc_reg[15:0] : acc_reg[15:0];
    assign final_sum = ((ZERO_TO_FFFF != 0) && (inv_sum == 16'h0000)) ? 16'hFFFF : inv_sum;
    assign in_hs     = s_axis_tvalid && tready_reg;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg  <= ACCUM;
            acc_reg    <= 32'h0;
            first_reg  <= 1'b1;
            tready_reg <= 1'b0;
            tvalid_reg <= 1'b0;
            tdata_reg  <= 16'h0000;
        end else begin
            case (state_reg)
                ACCUM: begin
                    tready_reg <= !(in_hs && s_axis_tlast);
                    if (in_hs) begin
                        acc_reg   <= beat_sum;
                        first_reg <= 1'b0;
                        if (s_axis_tlast) begin
                            state_reg <= FOLD1;
                        end
                    end
                end
                FOLD1: begin
                    acc_reg   <= {15'h0000, fold1_c, fold1_sum};
                    state_reg <= FOLD2;
                end
                FOLD2: begin
                    acc_reg   <= {16'h0000, fold2_sum};
                    state_reg <= OUT;
                end
                OUT: begin
                    // Result is loaded once from the fully folded accumulator, then held.
                    if (!tvalid_reg) begin
                        tvalid_reg <= 1'b1;
                        tdata_reg  <= final_sum;
                    end else if (csum_tready) begin
                        tvalid_reg <= 1'b0;
                        acc_reg    <= 32'h0;
                        first_reg  <= 1'b1;
                        tready_reg <= 1'b1;
                        state_reg  <= ACCUM;
                    end
                end
                default: state_reg <= ACCUM;
            endcase
        end
    end

    assign s_axis_tready = tready_reg;
    assign csum_tvalid   = tvalid_reg;
    assign csum_tdata    = tdata_reg;
endmodule
